victim_buffer: RTL
==================

Name: victim_buffer

Overview:
- Small fully-associative write-back victim buffer between the L2 cache's memory-side bus and physical memory.
- Occupies the slot the external write buffer fills today.
- Absorbs dirty lines evicted by L2, serves L2 read misses that hit a buffered victim without touching memory, and writes lines to memory only when a slot must be reclaimed.
- Never writes to memory on the L2 request's critical path except on full-buffer eviction.

Parameters:
ENTRIES, 4, number of victim slots (power of two, 2..8)
ADDR_W, 12, line address width (matches bus ADR)
LINE_W, 128, line data width
DRAIN_IDLE, 16, idle cycles before background drain (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
l2_adr  in  ADR_W  L2 request line address
l2_dat_m  in  LINE_W  L2 write data
l2_dat_s  out  LINE_W  read data to L2
l2_we  in  1  1 = write-back from L2, 0 = read fill
l2_stb  in  1  L2 strobe
l2_cyc  in  1  L2 cycle
l2_ack  out  1  one-cycle completion pulse to L2
mem_adr  out  ADDR_W  memory address
mem_dat_m  out  LINE_W  memory write data
mem_dat_s  in  LINE_W  memory read data
mem_we  out  1  memory write enable
mem_stb  out  1  memory strobe
mem_cyc  out  1  memory cycle
mem_ack  in  1  memory completion

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Entry state: each entry holds valid, tag[ADDR_W], data[LINE_W] and an LRU age of clog2(ENTRIES) bits.
- Dirty tracking: every valid entry is dirty by construction (filled only by write-backs), so no dirty bit is kept.
- Reset: all valid bits cleared, ages set to entry index, state IDLE. l2_ack, l2_dat_s, mem_stb, mem_cyc, mem_we, mem_adr and mem_dat_m are all 0.
- Request acceptance: a request is taken only in IDLE with l2_stb && l2_cyc.
- L2 handshake: L2 holds its inputs stable until l2_ack. l2_ack is exactly one cycle, and the block returns to IDLE the cycle after l2_ack.
- LRU update: on any hit or install, the touched entry's age goes to 0 and every entry younger than its old age is incremented. The victim is the valid entry with the maximum age.
- IDLE transitions:
  - write hit, or write miss with a free slot -> HIT_RESP; data is installed or overwritten on the transition edge.
  - read hit -> HIT_RESP; entry data is registered into l2_dat_s.
  - write miss with the buffer full -> EVICT_WB.
  - read miss -> MEM_READ.
- HIT_RESP: l2_ack = 1 for one cycle -> IDLE. Latency is request cycle + 1; no memory traffic. A read hit leaves the entry valid.
- EVICT_WB:
  - mem_cyc = mem_stb = mem_we = 1, with mem_adr/mem_dat_m taken from the LRU entry, held until mem_ack.
  - On mem_ack: the LRU slot is overwritten with l2_adr/l2_dat_m -> HIT_RESP.
- MEM_READ:
  - mem_cyc = mem_stb = 1, mem_we = 0, mem_adr = l2_adr, held until mem_ack.
  - On mem_ack: mem_dat_s is registered into l2_dat_s -> HIT_RESP. No allocation on a read miss.
- Free-slot choice: the lowest-index invalid entry.
- Tag match: at most one entry may ever match; a write hit overwrites in place and never duplicates.
- mem_ack outside EVICT_WB/MEM_READ/DRAIN is ignored. l2_stb dropped before ack is a protocol violation (undefined).
- Reset mid-operation: any in-flight memory transaction is abandoned (strobes low next cycle), and buffered dirty data is lost.

Optional Feature:
- Macro: VICTIM_DRAIN_EN.
- When defined:
  - An idle counter increments each IDLE cycle with no request and at least one valid entry. It clears on any request.
  - On reaching DRAIN_IDLE: state DRAIN writes the LRU entry to memory (same signalling as EVICT_WB); on mem_ack the entry is invalidated -> IDLE.
  - An L2 request arriving during DRAIN waits until the drain completes and is then served from IDLE.
  - A read of the line being drained, issued after the drain, goes to memory.
- When undefined: no counter and no DRAIN state; entries leave only by eviction.

Decomposition:
- Package victim_buffer_pkg: the state enum (IDLE, HIT_RESP, EVICT_WB, MEM_READ, DRAIN) and the entry struct typedef {valid, tag, data}.
- One sub-module, vb_lru: age array, victim index, touch update, parameterized by ENTRIES.

Test Plan:
1. Write 0x010/data A; 2 cycles later read 0x010 -> each l2_ack exactly 1 cycle after accept, l2_dat_s = A, mem_stb never 1.
2. Read miss 0x020; mem_ack with B 3 cycles after mem_stb -> mem_adr = 0x020, mem_we = 0, l2_ack the cycle after mem_ack, l2_dat_s = B.
3. Write 0x001..0x004, read 0x001, write 0x005 -> memory write adr 0x002 with its data, then l2_ack. A subsequent read of 0x002 goes to memory; 0x001 hits.
4. Write 0x003 = C, then 0x003 = D -> no memory traffic; a read of 0x003 returns D, and exactly one entry is valid for 0x003.
5. rst asserted during EVICT_WB before mem_ack -> the next cycle mem_stb/mem_cyc/l2_ack = 0. A read of a previously buffered address issues a memory read.
6. (VICTIM_DRAIN_EN) Write 0x040, idle 16 cycles -> memory write 0x040. Assert l2_stb during the drain -> served only after mem_ack; a read of 0x040 goes to memory.

Source files
------------

// File: rtl/victim_buffer_pkg.sv
// Shared types for the victim buffer: controller states and the per-slot entry record.
// Line address and data widths live here so the entry struct and the ports agree.
package victim_buffer_pkg;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned LINE_W = 128;

   typedef enum logic [2:0] {
      IDLE,
      HIT_RESP,
      EVICT_WB,
      MEM_READ,
      DRAIN
   } state_t;

   // Every valid entry is dirty: slots are only ever filled by L2 write-backs.
   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] tag;
      logic [LINE_W-1:0] data;
   } entry_t;

endpackage

// File: rtl/vb_lru.sv
// Age-based LRU tracker: ages form a permutation of 0..ENTRIES-1, age 0 is most recent.
// victim_idx is the valid entry with the largest age.
module vb_lru #(
   parameter  int unsigned ENTRIES = 4,
   localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ENTRIES-1:0] valid,
   input  logic               touch_en,
   input  logic [IDX_W-1:0]   touch_idx,
   output logic [IDX_W-1:0]   victim_idx
);

   logic [IDX_W-1:0] age_q [ENTRIES];
   logic [IDX_W-1:0] age_d [ENTRIES];
   logic [IDX_W-1:0] best_age;
   logic             found;

   always_comb begin
      age_d = age_q;
      if (touch_en) begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (IDX_W'(i) == touch_idx) begin
               age_d[i] = '0;
            end else if (age_q[i] < age_q[touch_idx]) begin
               age_d[i] = age_q[i] + IDX_W'(1);
            end
         end
      end
   end

   always_comb begin
      victim_idx = '0;
      best_age   = '0;
      found      = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid[i] && (!found || age_q[i] > best_age)) begin
            victim_idx = IDX_W'(i);
            best_age   = age_q[i];
            found      = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) age_q[i] <= IDX_W'(i);
      end else begin
         age_q <= age_d;
      end
   end

endmodule

// File: rtl/victim_buffer.sv
// Fully-associative write-back victim buffer between the L2 memory-side bus and memory.
// Defining VICTIM_DRAIN_EN adds a background drain of the LRU line after DRAIN_IDLE idle cycles.
module victim_buffer
   import victim_buffer_pkg::*;
#(
   parameter int unsigned ENTRIES = 4
`ifdef VICTIM_DRAIN_EN
   ,
   parameter int unsigned DRAIN_IDLE = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] l2_adr,
   input  logic [LINE_W-1:0] l2_dat_m,
   output logic [LINE_W-1:0] l2_dat_s,
   input  logic              l2_we,
   input  logic              l2_stb,
   input  logic              l2_cyc,
   output logic              l2_ack,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [LINE_W-1:0] mem_dat_m,
   input  logic [LINE_W-1:0] mem_dat_s,
   output logic              mem_we,
   output logic              mem_stb,
   output logic              mem_cyc,
   input  logic              mem_ack
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);

   state_t            state_q, state_d;
   entry_t            ent_q [ENTRIES];
   entry_t            ent_d [ENTRIES];
   logic              l2_ack_q, l2_ack_d;
   logic [LINE_W-1:0] l2_dat_s_q, l2_dat_s_d;
   logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
   logic [LINE_W-1:0] mem_dat_m_q, mem_dat_m_d;
   logic              mem_we_q, mem_we_d;
   logic              mem_stb_q, mem_stb_d;

   logic               req;
   logic [ENTRIES-1:0] valid;
   logic               hit, full;
   logic [IDX_W-1:0]   hit_idx, free_idx, victim_idx, touch_idx;
   logic               touch_en;

`ifdef VICTIM_DRAIN_EN
   localparam int unsigned CNT_W = $clog2(DRAIN_IDLE + 1);
   logic [CNT_W-1:0] idle_q, idle_d;
`endif

   assign req = l2_stb && l2_cyc;

   // Tag lookup and lowest-index free slot; write hits overwrite in place, so tags stay unique.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      full     = 1'b1;
      free_idx = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         valid[i] = ent_q[i].valid;
         if (ent_q[i].valid && ent_q[i].tag == l2_adr) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!ent_q[i].valid) begin
            full     = 1'b0;
            free_idx = IDX_W'(i);
         end
      end
   end

   vb_lru #(.ENTRIES(ENTRIES)) u_lru (
      .clk        (clk),
      .rst        (rst),
      .valid      (valid),
      .touch_en   (touch_en),
      .touch_idx  (touch_idx),
      .victim_idx (victim_idx)
   );

   // NOTE: every signal gets a default at the top of the block so no path infers a latch.
   always_comb begin
      state_d     = state_q;
      ent_d       = ent_q;
      l2_ack_d    = 1'b0;
      l2_dat_s_d  = l2_dat_s_q;
      mem_adr_d   = mem_adr_q;
      mem_dat_m_d = mem_dat_m_q;
      mem_we_d    = mem_we_q;
      mem_stb_d   = mem_stb_q;
      touch_en    = 1'b0;
      touch_idx   = hit_idx;
`ifdef VICTIM_DRAIN_EN
      idle_d      = '0;
`endif
      case (state_q)
         IDLE: begin
            if (req) begin
               if (l2_we && hit) begin
                  ent_d[hit_idx].data = l2_dat_m;
                  touch_en = 1'b1;
                  state_d  = HIT_RESP;
                  l2_ack_d = 1'b1;
               end else if (l2_we && !full) begin
                  ent_d[free_idx] = '{valid: 1'b1, tag: l2_adr, data: l2_dat_m};
                  touch_en  = 1'b1;
                  touch_idx = free_idx;
                  state_d   = HIT_RESP;
                  l2_ack_d  = 1'b1;
               end else if (l2_we) begin
                  state_d     = EVICT_WB;
                  mem_stb_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_adr_d   = ent_q[victim_idx].tag;
                  mem_dat_m_d = ent_q[victim_idx].data;
               end else if (hit) begin
                  l2_dat_s_d = ent_q[hit_idx].data;
                  touch_en   = 1'b1;
                  state_d    = HIT_RESP;
                  l2_ack_d   = 1'b1;
               end else begin
                  state_d     = MEM_READ;
                  mem_stb_d   = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_adr_d   = l2_adr;
                  mem_dat_m_d = '0;
               end
`ifdef VICTIM_DRAIN_EN
            end else if (|valid) begin
               if (idle_q == CNT_W'(DRAIN_IDLE - 1)) begin
                  state_d     = DRAIN;
                  mem_stb_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_adr_d   = ent_q[victim_idx].tag;
                  mem_dat_m_d = ent_q[victim_idx].data;
               end else begin
                  idle_d = idle_q + CNT_W'(1);
               end
`endif
            end
         end
         HIT_RESP: state_d = IDLE;
         EVICT_WB: begin
            if (mem_ack) begin
               ent_d[victim_idx] = '{valid: 1'b1, tag: l2_adr, data: l2_dat_m};
               touch_en    = 1'b1;
               touch_idx   = victim_idx;
               {mem_stb_d, mem_we_d, mem_adr_d, mem_dat_m_d} = '0;
               state_d     = HIT_RESP;
               l2_ack_d    = 1'b1;
            end
         end
         MEM_READ: begin
            if (mem_ack) begin
               l2_dat_s_d  = mem_dat_s;
               {mem_stb_d, mem_we_d, mem_adr_d, mem_dat_m_d} = '0;
               state_d     = HIT_RESP;
               l2_ack_d    = 1'b1;
            end
         end
`ifdef VICTIM_DRAIN_EN
         DRAIN: begin
            if (mem_ack) begin
               ent_d[victim_idx].valid = 1'b0;
               {mem_stb_d, mem_we_d, mem_adr_d, mem_dat_m_d} = '0;
               state_d     = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // NOTE: only valid bits are reset; tag/data storage is gated by valid and needs no reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         l2_ack_q    <= 1'b0;
         l2_dat_s_q  <= '0;
         mem_adr_q   <= '0;
         mem_dat_m_q <= '0;
         mem_we_q    <= 1'b0;
         mem_stb_q   <= 1'b0;
         for (int i = 0; i < ENTRIES; i++) ent_q[i].valid <= 1'b0;
      end else begin
         state_q     <= state_d;
         l2_ack_q    <= l2_ack_d;
         l2_dat_s_q  <= l2_dat_s_d;
         mem_adr_q   <= mem_adr_d;
         mem_dat_m_q <= mem_dat_m_d;
         mem_we_q    <= mem_we_d;
         mem_stb_q   <= mem_stb_d;
         ent_q       <= ent_d;
      end
   end

`ifdef VICTIM_DRAIN_EN
   always_ff @(posedge clk) begin
      if (rst) idle_q <= '0;
      else     idle_q <= idle_d;
   end
`endif

   assign l2_ack    = l2_ack_q;
   assign l2_dat_s  = l2_dat_s_q;
   assign mem_adr   = mem_adr_q;
   assign mem_dat_m = mem_dat_m_q;
   assign mem_we    = mem_we_q;
   assign mem_stb   = mem_stb_q;
   assign mem_cyc   = mem_stb_q;

endmodule
